// File: rtl/mac_stream_pkg.sv
// Shared types and default operand formats for the two-channel MAC operand source.
// The widths match the fixed_mul operand formats: A is 6.10 and B is 4.8.
package mac_stream_pkg;

  localparam int MS_WI1 = 6;
  localparam int MS_WF1 = 10;
  localparam int MS_WI2 = 4;
  localparam int MS_WF2 = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mac_stream_source_if.sv
// A/B operand stream bundle between mac_stream_source (master) and its consumer (slave).
interface mac_stream_source_if #(
  parameter int A_DW = mac_stream_pkg::MS_WI1 + mac_stream_pkg::MS_WF1,
  parameter int B_DW = mac_stream_pkg::MS_WI2 + mac_stream_pkg::MS_WF2
);

  logic [A_DW-1:0] A_data;
  logic            A_valid;
  logic            A_ready;
  logic            A_last;
  logic [B_DW-1:0] B_data;
  logic            B_valid;
  logic            B_ready;
  logic            B_last;

  modport master (
    output A_data, A_valid, A_last, B_data, B_valid, B_last,
    input  A_ready, B_ready
  );

  modport slave (
    input  A_data, A_valid, A_last, B_data, B_valid, B_last,
    output A_ready, B_ready
  );

endinterface

// File: rtl/stream_chan_tx.sv
// One replay channel: a vector store plus a registered valid/ready stream with a last flag.
// The beat registers always hold the entry at the post-handshake pointer, so data holds across stalls.
module stream_chan_tx #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          load,
  input  logic [AW:0]   len,
  input  logic          run,
  input  logic          ready,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          last,
  output logic          finished
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW:0]   ptr_q, ptr_d, ptr_n;
  logic [AW:0]   len_q, len_d;
  logic          fin_q, fin_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [DW-1:0] data_q, data_d;
  logic          hs;

  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise a path that skips it infers a latch.
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    fin_d   = fin_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    hs      = valid_q & ready;
    ptr_n   = ptr_q + (AW + 1)'(hs);

    if (wr_en) mem_d[wr_addr] = wr_data;

    if (load) begin
      len_d   = (len > DEPTH_L) ? DEPTH_L : len;
      ptr_d   = '0;
      fin_d   = (len == '0);
      valid_d = 1'b0;
      last_d  = 1'b0;
      data_d  = '0;
    end else if (run) begin
      // Look ahead to the pointer after this cycle's handshake so the next beat is registered.
      ptr_d   = ptr_n;
      fin_d   = fin_q | (hs & last_q);
      valid_d = (ptr_n < len_q);
      last_d  = valid_d && (ptr_n == len_q - (AW + 1)'(1));
      data_d  = valid_d ? mem_q[ptr_n[AW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the store is small and must read back as zero after reset, so it sits in resettable flops.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      fin_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      fin_q   <= fin_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign last     = last_q;
  assign finished = fin_q | (hs & last_q);

endmodule

// File: rtl/mac_stream_source.sv
// Two-channel operand replay source for fixed_mul: loads A/B vectors, then streams them on start.
// The top owns sequencing; each channel tracks its own length, pointer and completion.
module mac_stream_source
  import mac_stream_pkg::*;
#(
  parameter int WI1   = MS_WI1,
  parameter int WF1   = MS_WF1,
  parameter int WI2   = MS_WI2,
  parameter int WF2   = MS_WF2,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WI1+WF1-1:0]   wr_a_data,
  input  logic [WI2+WF2-1:0]   wr_b_data,
  input  logic                 start,
  input  logic [AW:0]          len_a,
  input  logic [AW:0]          len_b,
  output logic                 busy,
  output logic                 done,
  mac_stream_source_if.master  strm
);

  state_e state_q;
  logic   busy_q;
  logic   done_q;
  logic   idle;
  logic   run;
  logic   load;
  logic   wr_ok;
  logic   a_fin;
  logic   b_fin;

  assign idle  = (state_q == ST_IDLE);
  assign run   = (state_q == ST_STREAM);
  // Writes and start are only honoured in IDLE so the stores stay frozen during a transfer.
  assign load  = start & idle;
  assign wr_ok = wr_en & idle;

  stream_chan_tx #(.DW(WI1 + WF1), .DEPTH(DEPTH), .AW(AW)) u_chan_a (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_ok),
    .wr_addr  (wr_addr),
    .wr_data  (wr_a_data),
    .load     (load),
    .len      (len_a),
    .run      (run),
    .ready    (strm.A_ready),
    .data     (strm.A_data),
    .valid    (strm.A_valid),
    .last     (strm.A_last),
    .finished (a_fin)
  );

  stream_chan_tx #(.DW(WI2 + WF2), .DEPTH(DEPTH), .AW(AW)) u_chan_b (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_ok),
    .wr_addr  (wr_addr),
    .wr_data  (wr_b_data),
    .load     (load),
    .len      (len_b),
    .run      (run),
    .ready    (strm.B_ready),
    .data     (strm.B_data),
    .valid    (strm.B_valid),
    .last     (strm.B_last),
    .finished (b_fin)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_STREAM;
            busy_q  <= 1'b1;
          end
        end
        ST_STREAM: begin
          // Finished includes a final handshake on this edge, so done follows it by one cycle.
          if (a_fin && b_fin) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mac_stream_source.sv
// Directed bench for mac_stream_source: a scoreboard of expected {last,data} beats per channel,
// popped by a negedge monitor that also checks that beats hold steady while stalled.
module tb_mac_stream_source;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_a_data = '0;
  logic [11:0] wr_b_data = '0;
  logic        start = 1'b0;
  logic [4:0]  len_a = '0;
  logic [4:0]  len_b = '0;
  logic        busy;
  logic        done;

  mac_stream_source_if #(.A_DW(16), .B_DW(12)) strm ();

  mac_stream_source dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_a_data (wr_a_data),
    .wr_b_data (wr_b_data),
    .start     (start),
    .len_a     (len_a),
    .len_b     (len_b),
    .busy      (busy),
    .done      (done),
    .strm      (strm)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [16:0] qa [$];
  logic [12:0] qb [$];
  logic [15:0] ma [16];
  logic [11:0] mb [16];

  logic        pa_v, pa_r, pb_v, pb_r;
  logic [16:0] pa_d, ea;
  logic [12:0] pb_d, eb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    if (!reset) begin
      pa_v = 1'b0; pa_r = 1'b0; pb_v = 1'b0; pb_r = 1'b0;
    end else begin
      if (pa_v && !pa_r) begin
        check("a_hold_valid", strm.A_valid, 1);
        check("a_hold_beat", {strm.A_last, strm.A_data}, pa_d);
      end
      if (pb_v && !pb_r) begin
        check("b_hold_valid", strm.B_valid, 1);
        check("b_hold_beat", {strm.B_last, strm.B_data}, pb_d);
      end
      if (strm.A_valid && strm.A_ready) begin
        if (qa.size() == 0) check("a_extra_beat", 1, 0);
        else begin
          ea = qa.pop_front();
          check("a_beat", {strm.A_last, strm.A_data}, ea);
        end
      end
      if (strm.B_valid && strm.B_ready) begin
        if (qb.size() == 0) check("b_extra_beat", 1, 0);
        else begin
          eb = qb.pop_front();
          check("b_beat", {strm.B_last, strm.B_data}, eb);
        end
      end
      pa_v = strm.A_valid; pa_r = strm.A_ready; pa_d = {strm.A_last, strm.A_data};
      pb_v = strm.B_valid; pb_r = strm.B_ready; pb_d = {strm.B_last, strm.B_data};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [15:0] a, input logic [11:0] b);
    wr_en = 1'b1; wr_addr = 4'(i); wr_a_data = a; wr_b_data = b;
    ma[i] = a; mb[i] = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_a_valid"}, strm.A_valid, 0);
    check({tag, "_b_valid"}, strm.B_valid, 0);
    check({tag, "_a_last"}, strm.A_last, 0);
    check({tag, "_b_last"}, strm.B_last, 0);
    check({tag, "_a_data"}, strm.A_data, 0);
    check({tag, "_b_data"}, strm.B_data, 0);
  endtask

  // Runs one transfer; rnd applies random backpressure, poke fires start/wr_en mid-transfer.
  task automatic xfer(input int la, input int lb, input bit rnd, input bit poke);
    int ca, cb, done_k;
    ca = (la > 16) ? 16 : la;
    cb = (lb > 16) ? 16 : lb;
    for (int i = 0; i < ca; i++) qa.push_back({(i == ca - 1), ma[i]});
    for (int i = 0; i < cb; i++) qb.push_back({(i == cb - 1), mb[i]});
    len_a = 5'(la); len_b = 5'(lb);
    strm.A_ready = 1'b1; strm.B_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 300 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_after_start", busy, 1);
      if (k == 2 && !rnd) begin
        check("a_first_valid", strm.A_valid, (ca != 0));
        check("b_first_valid", strm.B_valid, (cb != 0));
      end
      if (done) done_k = k;
      else begin
        step();
        start = 1'b0; wr_en = 1'b0;
        if (rnd) begin
          strm.A_ready = 1'($urandom_range(0, 1));
          strm.B_ready = 1'($urandom_range(0, 1));
        end
        if (poke && k == 2) begin
          start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0;
          wr_a_data = 16'h03ff; wr_b_data = 12'h3ff;
        end
      end
    end
    check("done_seen", (done_k != 0), 1);
    if (!rnd) check("done_latency", done_k, ((ca > cb) ? ca : cb) + 2);
    strm.A_ready = 1'b1; strm.B_ready = 1'b1;
    step();
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    qa.delete(); qb.delete();
    step();
  endtask

  initial begin
    strm.A_ready = 1'b1;
    strm.B_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin ma[i] = '0; mb[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    step();

    for (int i = 0; i < 4; i++) load(i, 16'(i + 1), 12'(16 * i));
    xfer(4, 4, 1'b0, 1'b0);
    xfer(5, 2, 1'b0, 1'b0);
    xfer(0, 3, 1'b0, 1'b0);
    xfer(0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) load(i, 16'($urandom), 12'($urandom));
    xfer(16, 16, 1'b1, 1'b0);

    xfer(4, 4, 1'b0, 1'b1);
    xfer(4, 4, 1'b0, 1'b0);
    xfer(20, 3, 1'b0, 1'b0);

    // Abort after two handshakes on each channel.
    for (int i = 0; i < 4; i++) begin
      qa.push_back({(i == 3), ma[i]});
      qb.push_back({(i == 3), mb[i]});
    end
    len_a = 5'd4; len_b = 5'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("abort");
    check("abort_a_beats_left", qa.size(), 2);
    check("abort_b_beats_left", qb.size(), 2);
    qa.delete(); qb.delete();
    for (int i = 0; i < 16; i++) begin ma[i] = '0; mb[i] = '0; end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_idle", busy, 0);
    end
    step();
    xfer(4, 4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
